agc_gain_sequencer: RTL and testbench

AGC_GAIN_SEQUENCER -- requirements
Module: agc_gain_sequencer

---
 rtl/agc_gain_sequencer.sv | 138 +++++++++++++
 tb/tb_agc_gain_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_sequencer.sv
// AGC gain sequencer: measures the window peak magnitude and steps the
// gain code toward the target, with a dead-band and a post-change hold.
module agc_gain_sequencer #(
  parameter int WIN_LOG2 = 4,
  parameter int GAIN_W   = 5,
  parameter int HYST     = 8,
  parameter int HOLD_N   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [7:0]        sample,
  input  logic [7:0]        target,
  input  logic              freeze,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_upd,
  output logic [7:0]        peak,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int CW = WIN_LOG2 + 1;
  localparam int HW = (HOLD_N > 0) ? $clog2(HOLD_N + 1) : 1;
  localparam logic [CW-1:0] WIN = CW'(2 ** WIN_LOG2);
  localparam logic [HW-1:0] HLIM = HW'(HOLD_N);
  localparam logic [GAIN_W-1:0] GMAX = {GAIN_W{1'b1}};
  localparam logic [GAIN_W-1:0] GRST = GAIN_W'(2 ** (GAIN_W - 1));
  localparam logic [8:0] H9 = 9'(HYST);

  state_t            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              upd_q, upd_d;
  logic [7:0]        peak_q, peak_d;
  logic [6:0]        rpk_q, rpk_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic [7:0]    neg;
  logic [6:0]    mag;
  logic [6:0]    base_pk, new_pk;
  logic [CW-1:0] new_cnt;
  logic [HW-1:0] hold_nx;
  logic [8:0]    pk9, tg9;
  logic          atk, rel;

  // -128 has no positive counterpart in 8 bits; clamp it to 127
  assign neg = ~sample + 8'd1;
  assign mag = !sample[7] ? sample[6:0] :
               (sample == 8'h80) ? 7'h7f : neg[6:0];

  assign base_pk = (state_q == IDLE) ? 7'd0 : rpk_q;
  assign new_pk  = (mag > base_pk) ? mag : base_pk;
  assign new_cnt = ((state_q == IDLE) ? '0 : cnt_q) + CW'(1);
  assign hold_nx = hold_q + HW'(1);

  // 9-bit compares so target+HYST and peak+HYST cannot wrap
  assign pk9 = {1'b0, peak_q};
  assign tg9 = {1'b0, target};
  assign atk = (pk9 > tg9 + H9) && (gain_q != '0);
  assign rel = (pk9 + H9 < tg9) && (gain_q != GMAX);

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    upd_d   = 1'b0;
    peak_d  = peak_q;
    rpk_d   = rpk_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, MEASURE: begin
        if (sample_valid) begin
          rpk_d   = new_pk;
          cnt_d   = new_cnt;
          state_d = MEASURE;
          if (new_cnt == WIN) begin
            state_d = DECIDE;
            peak_d  = {1'b0, new_pk};
          end
        end
      end
      DECIDE: begin
        rpk_d   = '0;
        cnt_d   = '0;
        hold_d  = '0;
        state_d = MEASURE;
        if (!freeze && (atk || rel)) begin
          gain_d  = atk ? gain_q - GAIN_W'(1) : gain_q + GAIN_W'(1);
          upd_d   = 1'b1;
          state_d = (HOLD_N == 0) ? MEASURE : HOLD;
        end
      end
      HOLD: begin
        if (sample_valid) begin
          hold_d = hold_nx;
          if (hold_nx == HLIM) begin
            state_d = MEASURE;
            rpk_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gain_q  <= GRST;
      upd_q   <= 1'b0;
      peak_q  <= '0;
      rpk_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      upd_q   <= upd_d;
      peak_q  <= peak_d;
      rpk_q   <= rpk_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign gain     = gain_q;
  assign gain_upd = upd_q;
  assign peak     = peak_q;
  assign state    = state_q;

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Self-checking bench for agc_gain_sequencer: table-driven windows with a
// scoreboard queue, plus gap, drop, limit and reset sequences.
module tb_agc_gain_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] target;
  logic       freeze;
  logic [4:0] gain;
  logic       gain_upd;
  logic [7:0] peak;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  agc_gain_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .sample_valid(sample_valid), .sample(sample),
    .target(target), .freeze(freeze),
    .gain(gain), .gain_upd(gain_upd),
    .peak(peak), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] fill;
    logic [7:0] spec;
    int         sidx;
    logic [7:0] tgt;
    bit         frz;
    logic [7:0] epk;
    logic [4:0] eg;
    bit         eu;
  } vec_t;

  typedef struct {
    logic [7:0] pk;
    logic [4:0] g;
    bit         u;
  } exp_t;

  vec_t tbl[11];
  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    sample_valid = 1'b1;
    sample = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic run_win(input logic [7:0] fill, input logic [7:0] spec,
                         input int sidx, input logic [7:0] tgt,
                         input bit frz, input logic [7:0] epk,
                         input logic [4:0] eg, input bit eu);
    exp_t e;
    target = tgt;
    freeze = frz;
    for (int i = 0; i < 16; i++) begin
      send((i == sidx) ? spec : fill);
      if (i == 14) chk("meas_state", int'(state), 1);
    end
    sb.push_back('{epk, eg, eu});
    chk("dec_state", int'(state), 2);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("peak", int'(peak), int'(e.pk));
      tick();
      chk("gain", int'(gain), int'(e.g));
      chk("upd", int'(gain_upd), int'(e.u));
      chk("exit_state", int'(state), e.u ? 3 : 1);
      if (e.u) begin
        send(8'd127);
        chk("upd_pulse", int'(gain_upd), 0);
        send(8'd127);
        send(8'd127);
        chk("hold_state", int'(state), 3);
        send(8'd127);
        chk("hold_exit", int'(state), 1);
      end
    end
    freeze = 1'b0;
  endtask

  initial begin
    int g;
    tbl[0]  = '{8'd100, 8'd0,   -1, 8'd64,  1'b0, 8'd100, 5'd15, 1'b1};
    tbl[1]  = '{8'hEC,  8'd0,   -1, 8'd64,  1'b0, 8'd20,  5'd16, 1'b1};
    tbl[2]  = '{8'd60,  8'd0,   -1, 8'd64,  1'b0, 8'd60,  5'd16, 1'b0};
    tbl[3]  = '{8'd10,  8'h80,   7, 8'd64,  1'b0, 8'd127, 5'd15, 1'b1};
    tbl[4]  = '{8'd127, 8'd0,   -1, 8'd64,  1'b1, 8'd127, 5'd15, 1'b0};
    tbl[5]  = '{8'd64,  8'd72,   0, 8'd64,  1'b0, 8'd72,  5'd15, 1'b0};
    tbl[6]  = '{8'd73,  8'd0,   -1, 8'd64,  1'b0, 8'd73,  5'd14, 1'b1};
    tbl[7]  = '{8'd55,  8'd0,   -1, 8'd64,  1'b0, 8'd55,  5'd15, 1'b1};
    tbl[8]  = '{8'd56,  8'd0,   -1, 8'd64,  1'b0, 8'd56,  5'd15, 1'b0};
    tbl[9]  = '{8'd127, 8'd0,   -1, 8'd250, 1'b0, 8'd127, 5'd16, 1'b1};
    tbl[10] = '{8'd0,   8'd0,   -1, 8'd0,   1'b0, 8'd0,   5'd16, 1'b0};

    rst_n = 1'b0;
    sample_valid = 1'b1;
    sample = 8'd100;
    target = 8'd64;
    freeze = 1'b0;
    tick();
    tick();
    chk("rst_state_low", int'(state), 0);
    sample_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_gain", int'(gain), 16);
    chk("rst_peak", int'(peak), 0);
    chk("rst_upd", int'(gain_upd), 0);
    chk("rst_state", int'(state), 0);

    foreach (tbl[i])
      run_win(tbl[i].fill, tbl[i].spec, tbl[i].sidx, tbl[i].tgt,
              tbl[i].frz, tbl[i].epk, tbl[i].eg, tbl[i].eu);

    // valid gaps stall counting; a sample in DECIDE is dropped
    target = 8'd64;
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      send(8'd60);
      if (i == 14) chk("gap_meas", int'(state), 1);
    end
    chk("gap_decide", int'(state), 2);
    chk("gap_peak", int'(peak), 60);
    send(8'd127);
    chk("drop_state", int'(state), 1);
    chk("drop_upd", int'(gain_upd), 0);
    run_win(8'd60, 8'd0, -1, 8'd64, 1'b0, 8'd60, 5'd16, 1'b0);

    g = 16;
    while (g < 31) begin
      g++;
      run_win(8'd0, 8'd0, -1, 8'd64, 1'b0, 8'd0, 5'(g), 1'b1);
    end
    run_win(8'd0, 8'd0, -1, 8'd64, 1'b0, 8'd0, 5'd31, 1'b0);
    while (g > 0) begin
      g--;
      run_win(8'd127, 8'd0, -1, 8'd64, 1'b0, 8'd127, 5'(g), 1'b1);
    end
    run_win(8'd127, 8'd0, -1, 8'd64, 1'b0, 8'd127, 5'd0, 1'b0);

    // reset mid-window discards the partial window
    for (int i = 0; i < 10; i++) send(8'd127);
    rst_n = 1'b0;
    sample_valid = 1'b1;
    sample = 8'd127;
    tick();
    chk("mrst_state", int'(state), 0);
    chk("mrst_gain", int'(gain), 16);
    chk("mrst_peak", int'(peak), 0);
    chk("mrst_upd", int'(gain_upd), 0);
    sample_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    run_win(8'd100, 8'd0, -1, 8'd64, 1'b0, 8'd100, 5'd15, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
